// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: ROM address/data, downstream control and the IF/ID register.
// Latency: none, wiring only.
// Backpressure: stall and branch_taken flow from consumer (slave) to fetch (master).
interface fetch_unit_if #(
  parameter int BUS_SIZE = 32,
  parameter int DIR_SIZE = 32
);
  // ROM side
  logic [DIR_SIZE-1:0] dir;
  logic [BUS_SIZE-1:0] opCode;
  // Downstream control
  logic                stall;
  logic                branch_taken;
  logic [DIR_SIZE-1:0] branch_target;
  // IF/ID pipeline register and debug counter
  logic [BUS_SIZE-1:0] if_opCode;
  logic [DIR_SIZE-1:0] if_pc;
  logic                if_valid;
  logic [31:0]         fetch_count;

  // Fetch unit view
  modport master (
    output dir,
    input  opCode,
    input  stall,
    input  branch_taken,
    input  branch_target,
    output if_opCode,
    output if_pc,
    output if_valid,
    output fetch_count
  );

  // ROM / decoder / execute view
  modport slave (
    input  dir,
    output opCode,
    output stall,
    output branch_taken,
    output branch_target,
    input  if_opCode,
    input  if_pc,
    input  if_valid,
    input  fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: drives ROM address from PC, loads IF/ID, folds J locally, accepts BEQ redirects.
// Latency: one cycle from dir to IF/ID; one BOOT cycle after reset release before the first fetch.
// Backpressure: stall freezes PC, IF/ID and counter; a taken branch overrides stall and flushes IF/ID.
module fetch_unit #(
  parameter int BUS_SIZE  = 32,
  parameter int DIR_SIZE  = 32,
  parameter int MEM_DEPTH = 256,
  parameter int RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.master bus
);

  // PC lives in the low log2(MEM_DEPTH) bits; everything above is forced to zero.
  localparam logic [DIR_SIZE-1:0] PC_MASK = DIR_SIZE'(MEM_DEPTH - 1);
  localparam logic [DIR_SIZE-1:0] PC_RST  = DIR_SIZE'(RESET_PC) & PC_MASK;
  localparam logic [DIR_SIZE-1:0] ONE     = DIR_SIZE'(1);
  localparam logic [5:0]          OP_J    = 6'b000010;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [DIR_SIZE-1:0] pc_q;
  logic [BUS_SIZE-1:0] if_opcode_q;
  logic [DIR_SIZE-1:0] if_pc_q;
  logic                if_valid_q;
  logic [31:0]         fetch_count_q;

  // Candidate next-PC values; all derived from registered PC plus inputs, never fed back to dir.
  logic                is_jump_d;
  logic [DIR_SIZE-1:0] jump_off_d;
  logic [DIR_SIZE-1:0] pc_seq_d;
  logic [DIR_SIZE-1:0] pc_jmp_d;
  logic [DIR_SIZE-1:0] pc_br_d;

  // Decode only J here; its 26-bit offset is relative to the word after the jump.
  always_comb begin
    is_jump_d  = (bus.opCode[BUS_SIZE-1 -: 6] == OP_J);
    jump_off_d = {{(DIR_SIZE-26){bus.opCode[25]}}, bus.opCode[25:0]};
    pc_seq_d   = (pc_q + ONE) & PC_MASK;
    pc_jmp_d   = (pc_q + ONE + jump_off_d) & PC_MASK;
    pc_br_d    = bus.branch_target & PC_MASK;
  end

  // Single state machine owning PC, IF/ID and the delivery counter; priority branch > stall > jump > sequential.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= PC_RST;
      if_opcode_q   <= '0;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          // One settling cycle: ROM address is presented but nothing is captured yet.
          state_q <= RUN;
        end
        RUN: begin
          if (bus.branch_taken) begin
            // Redirect wins even over stall: the wrong-path fetch must not survive.
            pc_q        <= pc_br_d;
            if_opcode_q <= '0;
            if_pc_q     <= '0;
            if_valid_q  <= 1'b0;
          end else if (bus.stall) begin
            // Hold everything; registers keep their values.
            pc_q <= pc_q;
          end else if (is_jump_d) begin
            // Jump consumed in fetch: bubble into IF/ID, the fall-through word is skipped.
            pc_q        <= pc_jmp_d;
            if_opcode_q <= '0;
            if_valid_q  <= 1'b0;
          end else begin
            pc_q          <= pc_seq_d;
            if_opcode_q   <= bus.opCode;
            if_pc_q       <= pc_q;
            if_valid_q    <= 1'b1;
            fetch_count_q <= fetch_count_q + 32'd1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  // Outputs come straight from registers; dir is stable for the whole cycle.
  assign bus.dir         = pc_q;
  assign bus.if_opCode   = if_opcode_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational ROM model and a delivery scoreboard.
// Expected deliveries are queued by the stimulus thread; a negedge monitor pops on each counter step.
// Directed cycle checks cover boot, jump, stall, branch-over-stall, wrap and async reset.
module tb_fetch_unit;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.BUS_SIZE(32), .DIR_SIZE(32)) bus ();

  fetch_unit #(
    .BUS_SIZE (32),
    .DIR_SIZE (32),
    .MEM_DEPTH(256),
    .RESET_PC (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: mostly ADDI-like words tagged with their index, plus a few special entries.
  logic [31:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 + 32'(i);
    rom[0]  = 32'h3C01_0001;
    rom[22] = 32'h0BFF_FFF9;   // J -7 -> 16
    rom[50] = 32'h0BFF_FFFF;   // J -1 -> self-loop
  end
  assign bus.opCode = rom[bus.dir[7:0]];

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int pc);
    exp_t e;
    e.pc = 32'(pc);
    e.op = rom[pc];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every increment of fetch_count is one delivered instruction.
  logic [31:0] prev_fc = 32'd0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_fc = 32'd0;
    end else if (bus.fetch_count != prev_fc) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_delivery: got pc=%0d op=0x%08h expected none", bus.if_pc, bus.if_opCode);
      end else begin
        e = exp_q.pop_front();
        check("deliv_pc",    bus.if_pc,       e.pc);
        check("deliv_op",    bus.if_opCode,   e.op);
        check("deliv_valid", 32'(bus.if_valid), 32'd1);
        check("deliv_count", bus.fetch_count, prev_fc + 32'd1);
      end
      prev_fc = bus.fetch_count;
    end
  end

  initial begin
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_dir",   bus.dir,                32'd0);
    check("rst_valid", 32'(bus.if_valid),      32'd0);
    check("rst_op",    bus.if_opCode,          32'd0);
    check("rst_ifpc",  bus.if_pc,              32'd0);
    check("rst_count", bus.fetch_count,        32'd0);
    #1 rst_n = 1'b1;

    // BOOT cycle, then ROM[0]
    tick();
    check("boot_dir",   bus.dir,           32'd0);
    check("boot_valid", 32'(bus.if_valid), 32'd0);
    push_exp(0);
    tick();
    check("first_dir",   bus.dir,           32'd1);
    check("first_op",    bus.if_opCode,     32'h3C01_0001);
    check("first_ifpc",  bus.if_pc,         32'd0);
    check("first_valid", 32'(bus.if_valid), 32'd1);
    check("first_count", bus.fetch_count,   32'd1);

    // Sequential run up to the jump at 22
    for (int i = 1; i <= 21; i++) push_exp(i);
    repeat (21) tick();
    check("pre_jump_dir", bus.dir, 32'd22);

    // J -7: lands on 16 with a bubble; word 23 is never delivered
    tick();
    check("jump_dir",   bus.dir,           32'd16);
    check("jump_valid", 32'(bus.if_valid), 32'd0);
    check("jump_count", bus.fetch_count,   32'd22);
    push_exp(16);
    push_exp(17);
    repeat (2) tick();
    check("post_jump_dir", bus.dir, 32'd18);

    // Redirect to 25, then one fetch so IF/ID holds a real instruction at pc 26
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd25;
    tick();
    check("br25_dir",   bus.dir,           32'd25);
    check("br25_valid", 32'(bus.if_valid), 32'd0);
    bus.branch_taken = 1'b0;
    push_exp(25);
    tick();
    check("pre_stall_dir", bus.dir, 32'd26);

    // Stall three cycles
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_dir",   bus.dir,         32'd26);
      check("stall_ifpc",  bus.if_pc,       32'd25);
      check("stall_op",    bus.if_opCode,   32'h2000_0019);
      check("stall_count", bus.fetch_count, 32'd25);
    end
    bus.stall = 1'b0;
    push_exp(26);
    tick();
    check("unstall_dir", bus.dir, 32'd27);

    // Branch together with stall: branch wins
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd45;
    tick();
    check("brstall_dir",   bus.dir,           32'd45);
    check("brstall_valid", 32'(bus.if_valid), 32'd0);
    check("brstall_ifpc",  bus.if_pc,         32'd0);
    check("brstall_op",    bus.if_opCode,     32'd0);
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    push_exp(45);
    tick();
    check("br45_op",   bus.if_opCode, 32'h2000_002D);
    check("br45_ifpc", bus.if_pc,     32'd45);
    check("br45_dir",  bus.dir,       32'd46);

    // Wrap at the top of the ROM
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd255;
    tick();
    check("br255_dir", bus.dir, 32'd255);
    bus.branch_taken = 1'b0;
    push_exp(255);
    tick();
    check("wrap_dir",   bus.dir,         32'd0);
    check("wrap_count", bus.fetch_count, 32'd28);

    // Out-of-range target reduces modulo depth
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd300;
    tick();
    check("br300_dir", bus.dir, 32'd44);

    // Jump -1 self-loop
    bus.branch_target = 32'd50;
    tick();
    check("br50_dir", bus.dir, 32'd50);
    bus.branch_taken = 1'b0;
    tick();
    check("selfloop_dir",   bus.dir,           32'd50);
    check("selfloop_valid", 32'(bus.if_valid), 32'd0);
    tick();
    check("selfloop2_dir", bus.dir,         32'd50);
    check("selfloop_count", bus.fetch_count, 32'd28);

    // Park at 100 and pull reset between edges
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'd100;
    tick();
    bus.branch_taken = 1'b0;
    check("pre_rst_dir",   bus.dir,                 32'd100);
    check("pre_rst_count", bus.fetch_count,         32'd28);
    check("pre_rst_drain", 32'(exp_q.size()),       32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dir",   bus.dir,           32'd0);
    check("async_rst_valid", 32'(bus.if_valid), 32'd0);
    check("async_rst_count", bus.fetch_count,   32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    tick();
    check("reboot_dir",   bus.dir,           32'd0);
    check("reboot_valid", 32'(bus.if_valid), 32'd0);
    push_exp(0);
    tick();
    check("refetch_dir",   bus.dir,         32'd1);
    check("refetch_op",    bus.if_opCode,   32'h3C01_0001);
    check("refetch_count", bus.fetch_count, 32'd1);
    push_exp(1);
    push_exp(2);
    repeat (2) tick();
    check("final_dir",   bus.dir,         32'd3);
    check("final_count", bus.fetch_count, 32'd3);
    tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
